l1_snoop_ctrl: RTL and testbench
================================

Name: l1_snoop_ctrl

Overview:
Parametrised successor to the L1 snoop-channel FSM: it accepts ACE snoops on AC, locks the L1 (FSM A and C), checks the MSHR, probes the cache array, and answers on CR and CD. New relative to the previous generation:
- AC request FIFO.
- Full ACE snoop-type decode, including invalidating and dataless snoops.
- Configurable line and CD widths.
- CD drain overlapped with the next snoop's lock and lookup.

Parameters:
ADDR_WIDTH, 32, AC address width
DATA_WIDTH, 64, CD beat width
LINE_WIDTH, 512, cache line width; must be a multiple of DATA_WIDTH; BEATS = LINE_WIDTH/DATA_WIDTH (≥1)
AC_FIFO_DEPTH, 2, buffered AC requests (power of 2, ≥1)

Ports:
clk in 1 clock
reset in 1 asynchronous active-high reset
ac_valid in 1 / ac_ready out 1 / ac_addr in ADDR_WIDTH / ac_snoop in 4 / ac_prot in 3 (ignored)
cr_valid out 1 / cr_ready in 1 / cr_resp out 5 ({WasUnique,IsShared,PassDirty,Error,DataTransfer})
cd_valid out 1 / cd_ready in 1 / cd_data out DATA_WIDTH / cd_last out 1
lock_req out 1 request exclusive access to A and C
lock_gnt_a in 1 / lock_gnt_c in 1 grants (level, held while lock_req)
lock_rel out 1 one-cycle release pulse
mshr_lkp_valid out 1 / mshr_lkp_addr out ADDR_WIDTH lookup request
mshr_rsp_valid in 1 / mshr_hit in 1 / mshr_evict in 1 (hit entry is MI)
snp_req_valid out 1 / snp_req_ready in 1 / snp_req_addr out ADDR_WIDTH / snp_req_op out 2 (0 KEEP, 1 INV, 2 INV_NODATA)
snp_rsp_valid in 1 / snp_rsp_ready out 1 / snp_rsp_state in 2 (0 INVALID, 1 CLEAN, 2 DIRTY) / snp_rsp_unique in 1 / snp_rsp_data in LINE_WIDTH

Behaviour:
Reset:
- Asynchronous, active-high; all outputs 0.
- FIFO empty; FSM in IDLE; line buffer free.
- Reset mid-burst abandons the CD burst; no lock_rel is issued.

AC FIFO:
- ac_ready = !full.
- Push on ac_valid&&ac_ready; a push while full is impossible.
- Pop on entry into LOCK.

Snoop decode (ac_snoop):
- 0000, 0001, 0010, 0011, 1000 → op KEEP.
- 0111, 1001 → op INV.
- 1101 → op INV_NODATA.
- Any other code → unsupported.

FSM:
- IDLE: if FIFO non-empty → pop, go to LOCK.
- LOCK: lock_req=1 from this state until release. Wait for lock_gnt_a&&lock_gnt_c (any order, any delay).
  - If unsupported: go to CR with cr_resp=0 and skip the cache.
  - Otherwise go to LOOKUP.
- LOOKUP:
  - mshr_lkp_valid=1 for exactly one cycle; then wait for mshr_rsp_valid.
  - hit&&evict → go to CR with cr_resp=0 (writeback carries the data).
  - hit&&!evict → force op to KEEP.
  - Then go to CREQ.
- CREQ: snp_req_valid held until snp_req_ready; then go to CWAIT.
- CWAIT: snp_rsp_ready = !buf_busy.
  - On handshake with state≠INVALID and op≠INV_NODATA: capture the line into the buffer and set buf_busy.
  - cr_resp composition:
    - DataTransfer = captured.
    - PassDirty = DIRTY&&captured.
    - IsShared = (op==KEEP)&&state≠INVALID.
    - WasUnique = snp_rsp_unique.
    - Error = 0.
  - CleanShared (1000) with CLEAN: no capture, DataTransfer=0.
- CR: cr_valid held until cr_ready; on accept pulse lock_rel, deassert lock_req, go to IDLE.

CD engine (independent of FSM):
- While buf_busy: cd_valid=1, cd_data = buffer[beat*DATA_WIDTH +: DATA_WIDTH].
- beat increments on cd_ready; cd_last=1 when beat==BEATS-1.
- Accepting the last beat clears buf_busy and resets beat to 0.
- BEATS=1 gives a single beat with cd_last=1.

Overlap:
- The next snoop may run LOCK/LOOKUP/CREQ while CD drains.
- It stalls in CWAIT until the buffer is free.
- A snoop's CR is never issued before its own data is captured.

Latency (no backpressure, immediate grants/responses): AC accept to cr_valid = 6 cycles.

Decomposition:
- Shared package param_pkg:
  - snoop_op_t (KEEP/INV/INV_NODATA).
  - snp_state_t.
  - l1_snoop_state_t (IDLE, LOCK, LOOKUP, CREQ, CWAIT, CR).
  - ACE snoop opcode constants.
  - CRRESP bit-index constants.
- Sub-module: snoop_ac_fifo, a generic synchronous FIFO (DEPTH and WIDTH parameters) holding {addr, snoop}.

Test Plan:
- ReadUnique 0x1000, line DIRTY, unique, BEATS=8, cd_ready=1 → snp_req_op=INV; cr_resp=5'b10101; 8 CD beats, cd_last on beat 7; one lock_rel.
- ReadShared 0x2040, line CLEAN, not unique → op KEEP, cr_resp=5'b01001, BEATS beats.
- MakeInvalid 0x3000, line DIRTY → op INV_NODATA, no capture, cr_resp=5'b00000 with WasUnique as reported, cd_valid never asserted.
- ReadUnique with MSHR hit, evict=1 → no snp_req_valid, cr_resp=0, lock_rel pulse.
- ReadUnique with MSHR hit, evict=0 → op forced to KEEP, IsShared=1.
- Two back-to-back ReadClean (both DIRTY) with cd_ready toggling 1-in-3 → second held in CWAIT with snp_rsp_ready=0 until first cd_last accepted; FIFO full deasserts ac_ready.
- Unsupported code 0101 → cr_resp=0, no cache access.
- Reset asserted mid-CD burst → all outputs 0 asynchronously; FIFO empty after release.

Source files
------------

// File: rtl/l1_snoop_ctrl_pkg.sv
// Shared types and constants for the L1 snoop-channel controller:
// snoop op/state encodings, FSM states, ACE opcodes and CRRESP bit positions.
package l1_snoop_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_KEEP       = 2'd0,
    OP_INV        = 2'd1,
    OP_INV_NODATA = 2'd2
  } snoop_op_t;

  typedef enum logic [1:0] {
    SNP_INVALID = 2'd0,
    SNP_CLEAN   = 2'd1,
    SNP_DIRTY   = 2'd2
  } snp_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOCK,
    ST_LOOKUP,
    ST_CREQ,
    ST_CWAIT,
    ST_CR
  } l1_snoop_state_t;

  localparam logic [3:0] AC_READ_ONCE             = 4'b0000;
  localparam logic [3:0] AC_READ_SHARED           = 4'b0001;
  localparam logic [3:0] AC_READ_CLEAN            = 4'b0010;
  localparam logic [3:0] AC_READ_NOT_SHARED_DIRTY = 4'b0011;
  localparam logic [3:0] AC_READ_UNIQUE           = 4'b0111;
  localparam logic [3:0] AC_CLEAN_SHARED          = 4'b1000;
  localparam logic [3:0] AC_CLEAN_INVALID         = 4'b1001;
  localparam logic [3:0] AC_MAKE_INVALID          = 4'b1101;

  localparam int unsigned CR_WIDTH      = 5;
  localparam int unsigned CR_DATA_XFER  = 0;
  localparam int unsigned CR_ERROR      = 1;
  localparam int unsigned CR_PASS_DIRTY = 2;
  localparam int unsigned CR_IS_SHARED  = 3;
  localparam int unsigned CR_WAS_UNIQUE = 4;

  typedef struct packed {
    logic      supported;
    snoop_op_t op;
  } snoop_decode_t;

  // Map an ACE AC snoop code onto the cache-side operation.
  function automatic snoop_decode_t decode_snoop(input logic [3:0] code);
    snoop_decode_t d;
    d.supported = 1'b1;
    d.op        = OP_KEEP;
    case (code)
      AC_READ_ONCE, AC_READ_SHARED, AC_READ_CLEAN,
      AC_READ_NOT_SHARED_DIRTY, AC_CLEAN_SHARED: d.op = OP_KEEP;
      AC_READ_UNIQUE, AC_CLEAN_INVALID:          d.op = OP_INV;
      AC_MAKE_INVALID:                           d.op = OP_INV_NODATA;
      default:                                   d.supported = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/snoop_ac_fifo.sv
// Generic synchronous FIFO with registered space/data-available flags.
module snoop_ac_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 36
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic             wr_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push && wr_ready;
  assign do_pop    = pop && rd_valid;
  assign rd_data_c = mem[rptr];

  always_comb begin
    count_n = count + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wr_data;
  end

  // Flags come from the next count so they are flops, not decode of count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      wr_ready <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      if (do_push) wptr <= (DEPTH == 1) ? '0 : wptr + PTR_W'(1);
      if (do_pop)  rptr <= (DEPTH == 1) ? '0 : rptr + PTR_W'(1);
      count    <= count_n;
      wr_ready <= (count_n != CNT_W'(DEPTH));
      rd_valid <= (count_n != '0);
    end
  end

endmodule

// File: rtl/l1_snoop_ctrl.sv
// L1 snoop-channel controller: buffers ACE AC snoops, locks the L1, checks the
// MSHR, probes the array, answers on CR and drains line data on CD.
module l1_snoop_ctrl
  import l1_snoop_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned LINE_WIDTH    = 512,
  parameter int unsigned AC_FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ac_valid,
  output logic                  ac_ready,
  input  logic [ADDR_WIDTH-1:0] ac_addr,
  input  logic [3:0]            ac_snoop,
  input  logic [2:0]            ac_prot,
  output logic                  cr_valid,
  input  logic                  cr_ready,
  output logic [4:0]            cr_resp,
  output logic                  cd_valid,
  input  logic                  cd_ready,
  output logic [DATA_WIDTH-1:0] cd_data,
  output logic                  cd_last,
  output logic                  lock_req,
  input  logic                  lock_gnt_a,
  input  logic                  lock_gnt_c,
  output logic                  lock_rel,
  output logic                  mshr_lkp_valid,
  output logic [ADDR_WIDTH-1:0] mshr_lkp_addr,
  input  logic                  mshr_rsp_valid,
  input  logic                  mshr_hit,
  input  logic                  mshr_evict,
  output logic                  snp_req_valid,
  input  logic                  snp_req_ready,
  output logic [ADDR_WIDTH-1:0] snp_req_addr,
  output logic [1:0]            snp_req_op,
  input  logic                  snp_rsp_valid,
  output logic                  snp_rsp_ready,
  input  logic [1:0]            snp_rsp_state,
  input  logic                  snp_rsp_unique,
  input  logic [LINE_WIDTH-1:0] snp_rsp_data
);

  localparam int unsigned BEATS  = LINE_WIDTH / DATA_WIDTH;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned FIFO_W = ADDR_WIDTH + 4;

  l1_snoop_state_t       state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [3:0]            code_q, code_n;
  snoop_op_t             op_q, op_n;
  logic                  unsup_q, unsup_n;
  logic [4:0]            resp_n;
  logic                  lock_rel_n;
  logic                  capture_c;

  logic                  fifo_pop_c;
  logic                  fifo_rd_valid;
  logic [FIFO_W-1:0]     fifo_rd_c;
  snoop_decode_t         dec_c;
  snp_state_t            rsp_state_c;

  logic [LINE_WIDTH-1:0] line_q, line_n;
  logic [BEAT_W-1:0]     beat_q, beat_n;
  logic                  busy_n;
  logic                  unused_prot;

  assign unused_prot   = ^ac_prot;
  assign dec_c         = decode_snoop(fifo_rd_c[3:0]);
  assign rsp_state_c   = snp_state_t'(snp_rsp_state);
  assign mshr_lkp_addr = addr_q;
  assign snp_req_addr  = addr_q;
  assign snp_req_op    = 2'(op_q);
  assign cd_data       = line_q[DATA_WIDTH-1:0];

  snoop_ac_fifo #(
    .DEPTH (AC_FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_ac_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (ac_valid),
    .wr_data   ({ac_addr, ac_snoop}),
    .pop       (fifo_pop_c),
    .wr_ready  (ac_ready),
    .rd_valid  (fifo_rd_valid),
    .rd_data_c (fifo_rd_c)
  );

  // Snoop sequencing; CR response is built when leaving LOCK, LOOKUP or CWAIT.
  always_comb begin
    state_n    = state;
    addr_n     = addr_q;
    code_n     = code_q;
    op_n       = op_q;
    unsup_n    = unsup_q;
    resp_n     = cr_resp;
    lock_rel_n = 1'b0;
    fifo_pop_c = 1'b0;
    capture_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fifo_rd_valid) begin
          fifo_pop_c = 1'b1;
          addr_n     = fifo_rd_c[FIFO_W-1:4];
          code_n     = fifo_rd_c[3:0];
          op_n       = dec_c.op;
          unsup_n    = !dec_c.supported;
          state_n    = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (lock_gnt_a && lock_gnt_c) begin
          if (unsup_q) begin
            resp_n  = '0;
            state_n = ST_CR;
          end else begin
            state_n = ST_LOOKUP;
          end
        end
      end
      ST_LOOKUP: begin
        if (mshr_rsp_valid) begin
          if (mshr_hit && mshr_evict) begin
            resp_n  = '0;
            state_n = ST_CR;
          end else begin
            if (mshr_hit) op_n = OP_KEEP;
            state_n = ST_CREQ;
          end
        end
      end
      ST_CREQ: begin
        if (snp_req_ready) state_n = ST_CWAIT;
      end
      ST_CWAIT: begin
        if (snp_rsp_valid && snp_rsp_ready) begin
          // CleanShared on a clean line needs no data movement.
          capture_c = (rsp_state_c != SNP_INVALID) && (op_q != OP_INV_NODATA) &&
                      !((code_q == AC_CLEAN_SHARED) && (rsp_state_c == SNP_CLEAN));
          resp_n                = '0;
          resp_n[CR_DATA_XFER]  = capture_c;
          resp_n[CR_PASS_DIRTY] = capture_c && (rsp_state_c == SNP_DIRTY);
          resp_n[CR_IS_SHARED]  = (op_q == OP_KEEP) && (rsp_state_c != SNP_INVALID);
          resp_n[CR_WAS_UNIQUE] = snp_rsp_unique;
          state_n               = ST_CR;
        end
      end
      ST_CR: begin
        if (cr_ready) begin
          resp_n     = '0;
          lock_rel_n = 1'b1;
          state_n    = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // CD drain: the line buffer shifts down one beat per accepted transfer.
  always_comb begin
    line_n = line_q;
    beat_n = beat_q;
    busy_n = cd_valid;
    if (cd_valid && cd_ready) begin
      line_n = line_q >> DATA_WIDTH;
      if (beat_q == BEAT_W'(BEATS - 1)) begin
        busy_n = 1'b0;
        beat_n = '0;
      end else begin
        beat_n = beat_q + BEAT_W'(1);
      end
    end
    if (capture_c) begin
      line_n = snp_rsp_data;
      busy_n = 1'b1;
      beat_n = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      addr_q         <= '0;
      code_q         <= '0;
      op_q           <= OP_KEEP;
      unsup_q        <= 1'b0;
      cr_resp        <= '0;
      cr_valid       <= 1'b0;
      lock_req       <= 1'b0;
      lock_rel       <= 1'b0;
      mshr_lkp_valid <= 1'b0;
      snp_req_valid  <= 1'b0;
      snp_rsp_ready  <= 1'b0;
      line_q         <= '0;
      beat_q         <= '0;
      cd_valid       <= 1'b0;
      cd_last        <= 1'b0;
    end else begin
      state          <= state_n;
      addr_q         <= addr_n;
      code_q         <= code_n;
      op_q           <= op_n;
      unsup_q        <= unsup_n;
      cr_resp        <= resp_n;
      cr_valid       <= (state_n == ST_CR);
      lock_req       <= (state_n != ST_IDLE);
      lock_rel       <= lock_rel_n;
      mshr_lkp_valid <= (state != ST_LOOKUP) && (state_n == ST_LOOKUP);
      snp_req_valid  <= (state_n == ST_CREQ);
      snp_rsp_ready  <= (state_n == ST_CWAIT) && !busy_n;
      line_q         <= line_n;
      beat_q         <= beat_n;
      cd_valid       <= busy_n;
      cd_last        <= busy_n && (beat_n == BEAT_W'(BEATS - 1));
    end
  end

endmodule

// File: tb/tb_l1_snoop_ctrl.sv
// Directed bench for l1_snoop_ctrl with immediate lock/MSHR/cache responders.
module tb_l1_snoop_ctrl;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned LINE_W = 512;
  localparam int unsigned BEATS  = LINE_W / DATA_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              ac_valid, ac_ready;
  logic [ADDR_W-1:0] ac_addr;
  logic [3:0]        ac_snoop;
  logic [2:0]        ac_prot;
  logic              cr_valid, cr_ready;
  logic [4:0]        cr_resp;
  logic              cd_valid, cd_ready, cd_last;
  logic [DATA_W-1:0] cd_data;
  logic              lock_req, lock_gnt_a, lock_gnt_c, lock_rel;
  logic              mshr_lkp_valid, mshr_rsp_valid, mshr_hit, mshr_evict;
  logic [ADDR_W-1:0] mshr_lkp_addr;
  logic              snp_req_valid, snp_req_ready;
  logic [ADDR_W-1:0] snp_req_addr;
  logic [1:0]        snp_req_op;
  logic              snp_rsp_valid, snp_rsp_ready, snp_rsp_unique;
  logic [1:0]        snp_rsp_state;
  logic [LINE_W-1:0] snp_rsp_data;

  int n_asserts = 0;
  int n_fails   = 0;
  logic cd_toggle = 1'b0;

  always #5 clk = ~clk;

  assign lock_gnt_a     = lock_req;
  assign lock_gnt_c     = lock_req;
  assign mshr_rsp_valid = mshr_lkp_valid;

  l1_snoop_ctrl #(
    .ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W), .LINE_WIDTH(LINE_W), .AC_FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .reset(reset),
    .ac_valid(ac_valid), .ac_ready(ac_ready), .ac_addr(ac_addr), .ac_snoop(ac_snoop), .ac_prot(ac_prot),
    .cr_valid(cr_valid), .cr_ready(cr_ready), .cr_resp(cr_resp),
    .cd_valid(cd_valid), .cd_ready(cd_ready), .cd_data(cd_data), .cd_last(cd_last),
    .lock_req(lock_req), .lock_gnt_a(lock_gnt_a), .lock_gnt_c(lock_gnt_c), .lock_rel(lock_rel),
    .mshr_lkp_valid(mshr_lkp_valid), .mshr_lkp_addr(mshr_lkp_addr),
    .mshr_rsp_valid(mshr_rsp_valid), .mshr_hit(mshr_hit), .mshr_evict(mshr_evict),
    .snp_req_valid(snp_req_valid), .snp_req_ready(snp_req_ready), .snp_req_addr(snp_req_addr),
    .snp_req_op(snp_req_op),
    .snp_rsp_valid(snp_rsp_valid), .snp_rsp_ready(snp_rsp_ready), .snp_rsp_state(snp_rsp_state),
    .snp_rsp_unique(snp_rsp_unique), .snp_rsp_data(snp_rsp_data)
  );

  // Event recorder, sampled mid-cycle.
  int          cyc = 0;
  int          n_cr = 0, n_rel = 0, n_lkp = 0, n_req = 0, overlap_err = 0;
  int          ac_cyc = 0, cr_rise_cyc = 0;
  logic        cr_valid_d = 1'b0;
  logic [1:0]  last_op;
  logic [31:0] last_req_addr;
  logic [4:0]  cr_q[$];
  int          cr_cyc_q[$];
  logic [63:0] beat_q[$];
  logic        last_q[$];
  int          last_cyc_q[$];

  always @(negedge clk) begin
    cyc++;
    if (ac_valid && ac_ready) ac_cyc = cyc;
    if (cr_valid && !cr_valid_d) cr_rise_cyc = cyc;
    cr_valid_d = cr_valid;
    if (cr_valid && cr_ready) begin n_cr++; cr_q.push_back(cr_resp); cr_cyc_q.push_back(cyc); end
    if (lock_rel) n_rel++;
    if (mshr_lkp_valid) n_lkp++;
    if (snp_req_valid && snp_req_ready) begin n_req++; last_op = snp_req_op; last_req_addr = snp_req_addr; end
    if (cd_valid && cd_ready) begin
      beat_q.push_back(cd_data);
      last_q.push_back(cd_last);
      if (cd_last) last_cyc_q.push_back(cyc);
    end
    if (snp_rsp_ready && cd_valid) overlap_err++;
  end

  // cd_ready is either always high or high one cycle in three.
  initial begin
    int ph;
    ph = 0;
    cd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cd_ready = cd_toggle ? (ph == 0) : 1'b1;
      ph = (ph + 1) % 3;
    end
  end

  function automatic logic [LINE_W-1:0] make_line(input logic [15:0] tag);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < BEATS; i++) l[i*DATA_W +: DATA_W] = {tag, 16'h0, 32'(i)};
    return l;
  endfunction

  task automatic send_ac(input logic [31:0] addr, input logic [3:0] code);
    int guard;
    @(negedge clk);
    ac_valid = 1'b1; ac_addr = addr; ac_snoop = code; ac_prot = 3'd0;
    guard = 0;
    while (!ac_ready && guard < 200) begin @(negedge clk); guard++; end
    n_asserts++;
    if (!ac_ready) begin n_fails++; $display("FAIL ac_accept timeout: ac_ready=%b required 1", ac_ready); end
    @(posedge clk);
    #1;
    ac_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int guard;
    guard = 0;
    while (!(n_cr >= target && !cd_valid && !lock_req) && guard < 600) begin
      @(negedge clk); #1; guard++;
    end
    repeat (2) begin @(negedge clk); #1; end
    n_asserts++;
    if (n_cr < target || cd_valid || lock_req)
      begin n_fails++; $display("FAIL %s completion: cr count %0d required %0d", name, n_cr, target); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_asserts++;
    if ({ac_ready, cr_valid, cr_resp, cd_valid, cd_data, cd_last, lock_req, lock_rel, mshr_lkp_valid,
         snp_req_valid, snp_req_op, snp_rsp_ready} !== '0)
      begin n_fails++; $display("FAIL reset outputs: got nonzero, required all 0"); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_asserts++;
    if (ac_ready !== 1'b1) begin n_fails++; $display("FAIL reset ac_ready: got %b required 1", ac_ready); end
  endtask

  task automatic test_read_unique();
    int b_cr, b_rel, b_req, b_beat;
    logic [63:0] exp;
    b_cr = n_cr; b_rel = n_rel; b_req = n_req; b_beat = beat_q.size();
    snp_rsp_state = 2'd2; snp_rsp_unique = 1'b1; snp_rsp_data = make_line(16'h1000);
    send_ac(32'h1000, 4'b0111);
    wait_done(b_cr + 1, "read_unique");
    n_asserts++;
    if (n_req - b_req != 1 || last_op !== 2'd1 || last_req_addr !== 32'h1000)
      begin n_fails++; $display("FAIL read_unique req: n=%0d op=%0d addr=%h required 1/1/1000", n_req - b_req, last_op, last_req_addr); end
    n_asserts++;
    if (cr_q[b_cr] !== 5'b10101) begin n_fails++; $display("FAIL read_unique resp: got %b required 10101", cr_q[b_cr]); end
    n_asserts++;
    if (cr_rise_cyc - ac_cyc != 6) begin n_fails++; $display("FAIL read_unique latency: got %0d required 6", cr_rise_cyc - ac_cyc); end
    n_asserts++;
    if (n_rel - b_rel != 1) begin n_fails++; $display("FAIL read_unique lock_rel: got %0d required 1", n_rel - b_rel); end
    n_asserts++;
    if (beat_q.size() - b_beat != BEATS) begin n_fails++; $display("FAIL read_unique beats: got %0d required %0d", beat_q.size() - b_beat, BEATS); end
    else for (int i = 0; i < BEATS; i++) begin
      exp = {16'h1000, 16'h0, 32'(i)};
      n_asserts++;
      if (beat_q[b_beat+i] !== exp || last_q[b_beat+i] !== (i == BEATS - 1))
        begin n_fails++; $display("FAIL read_unique beat%0d: got %h/%b required %h/%b", i, beat_q[b_beat+i], last_q[b_beat+i], exp, (i == BEATS - 1)); end
    end
  endtask

  task automatic test_read_shared();
    int b_cr, b_beat;
    logic [63:0] exp;
    b_cr = n_cr; b_beat = beat_q.size();
    snp_rsp_state = 2'd1; snp_rsp_unique = 1'b0; snp_rsp_data = make_line(16'h2040);
    send_ac(32'h2040, 4'b0001);
    wait_done(b_cr + 1, "read_shared");
    n_asserts++;
    if (last_op !== 2'd0 || last_req_addr !== 32'h2040) begin n_fails++; $display("FAIL read_shared req: op=%0d addr=%h required 0/2040", last_op, last_req_addr); end
    n_asserts++;
    if (cr_q[b_cr] !== 5'b01001) begin n_fails++; $display("FAIL read_shared resp: got %b required 01001", cr_q[b_cr]); end
    n_asserts++;
    if (beat_q.size() - b_beat != BEATS) begin n_fails++; $display("FAIL read_shared beats: got %0d required %0d", beat_q.size() - b_beat, BEATS); end
    else begin
      exp = {16'h2040, 16'h0, 32'(BEATS - 1)};
      n_asserts++;
      if (beat_q[b_beat+BEATS-1] !== exp || last_q[b_beat+BEATS-1] !== 1'b1)
        begin n_fails++; $display("FAIL read_shared final beat: got %h required %h", beat_q[b_beat+BEATS-1], exp); end
    end
  endtask

  task automatic test_make_invalid();
    int b_cr, b_beat;
    b_cr = n_cr; b_beat = beat_q.size();
    snp_rsp_state = 2'd2; snp_rsp_unique = 1'b1; snp_rsp_data = make_line(16'h3000);
    send_ac(32'h3000, 4'b1101);
    wait_done(b_cr + 1, "make_invalid");
    n_asserts++;
    if (last_op !== 2'd2) begin n_fails++; $display("FAIL make_invalid op: got %0d required 2", last_op); end
    n_asserts++;
    if (cr_q[b_cr] !== 5'b10000) begin n_fails++; $display("FAIL make_invalid resp: got %b required 10000", cr_q[b_cr]); end
    n_asserts++;
    if (beat_q.size() != b_beat) begin n_fails++; $display("FAIL make_invalid cd beats: got %0d required 0", beat_q.size() - b_beat); end
  endtask

  task automatic test_mshr_evict();
    int b_cr, b_rel, b_req, b_lkp;
    b_cr = n_cr; b_rel = n_rel; b_req = n_req; b_lkp = n_lkp;
    mshr_hit = 1'b1; mshr_evict = 1'b1;
    send_ac(32'h3100, 4'b0111);
    wait_done(b_cr + 1, "mshr_evict");
    mshr_hit = 1'b0; mshr_evict = 1'b0;
    n_asserts++;
    if (n_req != b_req || n_lkp - b_lkp != 1) begin n_fails++; $display("FAIL mshr_evict access: req %0d lkp %0d required 0/1", n_req - b_req, n_lkp - b_lkp); end
    n_asserts++;
    if (cr_q[b_cr] !== 5'b00000) begin n_fails++; $display("FAIL mshr_evict resp: got %b required 00000", cr_q[b_cr]); end
    n_asserts++;
    if (n_rel - b_rel != 1) begin n_fails++; $display("FAIL mshr_evict lock_rel: got %0d required 1", n_rel - b_rel); end
  endtask

  task automatic test_mshr_hit_keep();
    int b_cr, b_beat;
    b_cr = n_cr; b_beat = beat_q.size();
    mshr_hit = 1'b1; mshr_evict = 1'b0;
    snp_rsp_state = 2'd2; snp_rsp_unique = 1'b1; snp_rsp_data = make_line(16'h3200);
    send_ac(32'h3200, 4'b0111);
    wait_done(b_cr + 1, "mshr_hit_keep");
    mshr_hit = 1'b0;
    n_asserts++;
    if (last_op !== 2'd0) begin n_fails++; $display("FAIL mshr_hit_keep op: got %0d required 0", last_op); end
    n_asserts++;
    if (cr_q[b_cr] !== 5'b11101) begin n_fails++; $display("FAIL mshr_hit_keep resp: got %b required 11101", cr_q[b_cr]); end
    n_asserts++;
    if (beat_q.size() - b_beat != BEATS) begin n_fails++; $display("FAIL mshr_hit_keep beats: got %0d required %0d", beat_q.size() - b_beat, BEATS); end
  endtask

  task automatic test_unsupported();
    int b_cr, b_rel, b_req, b_lkp;
    b_cr = n_cr; b_rel = n_rel; b_req = n_req; b_lkp = n_lkp;
    send_ac(32'h3300, 4'b0101);
    wait_done(b_cr + 1, "unsupported");
    n_asserts++;
    if (cr_q[b_cr] !== 5'b00000) begin n_fails++; $display("FAIL unsupported resp: got %b required 00000", cr_q[b_cr]); end
    n_asserts++;
    if (n_req != b_req || n_lkp != b_lkp) begin n_fails++; $display("FAIL unsupported access: req %0d lkp %0d required 0/0", n_req - b_req, n_lkp - b_lkp); end
    n_asserts++;
    if (n_rel - b_rel != 1) begin n_fails++; $display("FAIL unsupported lock_rel: got %0d required 1", n_rel - b_rel); end
  endtask

  task automatic test_back_to_back();
    int b_cr, b_beat, b_last, b_ovl;
    logic [63:0] exp;
    b_cr = n_cr; b_beat = beat_q.size(); b_last = last_cyc_q.size(); b_ovl = overlap_err;
    cd_toggle = 1'b1;
    snp_rsp_state = 2'd2; snp_rsp_unique = 1'b0; snp_rsp_data = make_line(16'h0b2b);
    send_ac(32'h4000, 4'b0010);
    send_ac(32'h4040, 4'b0010);
    send_ac(32'h4080, 4'b0010);
    @(negedge clk);
    n_asserts++;
    if (ac_ready !== 1'b0) begin n_fails++; $display("FAIL back_to_back full: ac_ready=%b required 0", ac_ready); end
    wait_done(b_cr + 3, "back_to_back");
    cd_toggle = 1'b0;
    n_asserts++;
    if (overlap_err != b_ovl) begin n_fails++; $display("FAIL back_to_back rsp_ready while draining: %0d cycles required 0", overlap_err - b_ovl); end
    for (int k = 0; k < 3; k++) begin
      n_asserts++;
      if (cr_q[b_cr+k] !== 5'b01101) begin n_fails++; $display("FAIL back_to_back resp%0d: got %b required 01101", k, cr_q[b_cr+k]); end
    end
    for (int k = 1; k < 3; k++) begin
      n_asserts++;
      if (cr_cyc_q[b_cr+k] <= last_cyc_q[b_last+k-1])
        begin n_fails++; $display("FAIL back_to_back cr%0d order: cr cycle %0d required after %0d", k, cr_cyc_q[b_cr+k], last_cyc_q[b_last+k-1]); end
    end
    n_asserts++;
    if (beat_q.size() - b_beat != 3 * BEATS) begin n_fails++; $display("FAIL back_to_back beats: got %0d required %0d", beat_q.size() - b_beat, 3 * BEATS); end
    else for (int i = 0; i < 3 * BEATS; i++) begin
      exp = {16'h0b2b, 16'h0, 32'(i % BEATS)};
      n_asserts++;
      if (beat_q[b_beat+i] !== exp || last_q[b_beat+i] !== ((i % BEATS) == BEATS - 1))
        begin n_fails++; $display("FAIL back_to_back beat%0d: got %h/%b required %h", i, beat_q[b_beat+i], last_q[b_beat+i], exp); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int b_beat, b_rel, b_cr, b_lkp, guard;
    b_beat = beat_q.size();
    cd_toggle = 1'b1;
    snp_rsp_state = 2'd2; snp_rsp_unique = 1'b1; snp_rsp_data = make_line(16'h5000);
    send_ac(32'h5000, 4'b0111);
    guard = 0;
    while (beat_q.size() < b_beat + 2 && guard < 200) begin @(negedge clk); #1; guard++; end
    n_asserts++;
    if (!cd_valid) begin n_fails++; $display("FAIL reset_mid_burst setup: cd_valid=%b required 1", cd_valid); end
    b_rel = n_rel; b_cr = n_cr; b_beat = beat_q.size(); b_lkp = n_lkp;
    #2; reset = 1'b1; #1;
    n_asserts++;
    if ({ac_ready, cr_valid, cr_resp, cd_valid, cd_data, cd_last, lock_req, lock_rel, mshr_lkp_valid,
         mshr_lkp_addr, snp_req_valid, snp_req_addr, snp_req_op, snp_rsp_ready} !== '0)
      begin n_fails++; $display("FAIL reset_mid_burst async: cd_valid=%b cd_data=%h required all outputs 0", cd_valid, cd_data); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cd_toggle = 1'b0;
    repeat (5) begin @(negedge clk); #1; end
    n_asserts++;
    if (ac_ready !== 1'b1 || lock_req !== 1'b0 || cd_valid !== 1'b0)
      begin n_fails++; $display("FAIL reset_mid_burst after: ac_ready=%b lock_req=%b cd_valid=%b required 1/0/0", ac_ready, lock_req, cd_valid); end
    n_asserts++;
    if (n_rel != b_rel || n_cr != b_cr || n_lkp != b_lkp || beat_q.size() != b_beat)
      begin n_fails++; $display("FAIL reset_mid_burst activity: rel %0d cr %0d lkp %0d beats %0d required 0", n_rel - b_rel, n_cr - b_cr, n_lkp - b_lkp, beat_q.size() - b_beat); end
  endtask

  initial begin
    ac_valid = 1'b0; ac_addr = '0; ac_snoop = '0; ac_prot = '0;
    cr_ready = 1'b1; snp_req_ready = 1'b1; snp_rsp_valid = 1'b1;
    snp_rsp_state = 2'd0; snp_rsp_unique = 1'b0; snp_rsp_data = '0;
    mshr_hit = 1'b0; mshr_evict = 1'b0;
    test_reset();
    test_read_unique();
    test_read_shared();
    test_make_invalid();
    test_mshr_evict();
    test_mshr_hit_keep();
    test_unsupported();
    test_back_to_back();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
